// File: rtl/mips_cpu_pkg.sv
// Shared CPU-side definitions: bus arbiter state encoding and shared-bus operation codes.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] BUS_OP_NONE  = 2'b00;
    localparam logic [1:0] BUS_OP_READ  = 2'b01;
    localparam logic [1:0] BUS_OP_WRITE = 2'b10;

    // The shared bus is word addressed; byte lanes carry the sub-word selection.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// Arbitrates one Avalon-style memory bus between the instruction-fetch and data requesters,
// holding each granted transfer stable until the bus drops waitrequest.
module mips_cpu_bus_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int MAX_CONSEC         = 4,
    parameter int RESET_VECTOR_CHECK = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam int CW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] consec_q, consec_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    op_q, op_d;

    logic d_pend;
    logic i_done;
    logic d_done;

    // Reserved tag; carries no logic.
    if (RESET_VECTOR_CHECK != 0) begin : g_reset_vector_reserved
    end

    assign d_pend = d_read | d_write;
    assign i_done = (state_q == GRANT_I) && !waitrequest;
    assign d_done = (state_q == GRANT_D) && !waitrequest;

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        op_d     = op_q;

        case (state_q)
            IDLE: begin
                // Data normally wins; the consecutive-grant count lets a waiting fetch through.
                if (d_pend && (!i_read || (consec_q < CW'(MAX_CONSEC)))) begin
                    state_d  = GRANT_D;
                    consec_d = i_read ? consec_q + CW'(1) : '0;
                    addr_d   = word_align(d_address);
                    be_d     = d_byteenable;
                    wdata_d  = d_writedata;
                    op_d     = d_write ? BUS_OP_WRITE : BUS_OP_READ;
                end else if (i_read) begin
                    state_d  = GRANT_I;
                    consec_d = '0;
                    addr_d   = word_align(i_address);
                    be_d     = '1;
                    wdata_d  = '0;
                    op_d     = BUS_OP_READ;
                end
            end
            GRANT_I, GRANT_D: begin
                // Always drop back to IDLE so a held request is never issued twice.
                if (!waitrequest) begin
                    state_d = IDLE;
                    op_d    = BUS_OP_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                op_d    = BUS_OP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            consec_q <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            op_q     <= BUS_OP_NONE;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
        end
    end

    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;
    assign read       = (op_q == BUS_OP_READ);
    assign write      = (op_q == BUS_OP_WRITE);

    assign i_readdata    = readdata;
    assign d_readdata    = readdata;
    assign i_waitrequest = i_read && !i_done;
    assign d_waitrequest = d_pend && !d_done;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scoreboard bench for mips_cpu_bus_arbiter: stimulus queues expected bus transfers,
// a negedge monitor checks each completed transfer against the queue.
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = '0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_writedata = '0;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        to_i;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    mips_cpu_bus_arbiter #(.MAX_CONSEC(4), .RESET_VECTOR_CHECK(0)) dut (
        .clk(clk),
        .reset(reset),
        .i_read(i_read),
        .i_address(i_address),
        .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_read(d_read),
        .d_write(d_write),
        .d_address(d_address),
        .d_byteenable(d_byteenable),
        .d_writedata(d_writedata),
        .d_readdata(d_readdata),
        .d_waitrequest(d_waitrequest),
        .address(address),
        .read(read),
        .write(write),
        .byteenable(byteenable),
        .writedata(writedata),
        .readdata(readdata),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic to_i, input logic [31:0] rdata);
        exp_t e;
        e.rd = rd; e.wr = wr; e.addr = addr; e.be = be; e.wd = wd; e.to_i = to_i; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_i, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (is_i ? (i_read && !i_waitrequest) : ((d_read || d_write) && !d_waitrequest)) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: got no completion expected completion within %0d cycles", is_i ? "i" : "d", bound);
    endtask

    // Monitor: every completed bus transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && (read || write) && !waitrequest) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_transfer: got addr %h expected no transfer", address);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bus_read", 32'(read), 32'(e.rd));
                chk("bus_write", 32'(write), 32'(e.wr));
                chk("bus_address", address, e.addr);
                chk("bus_byteenable", 32'(byteenable), 32'(e.be));
                if (e.wr) chk("bus_writedata", writedata, e.wd);
                if (e.to_i) begin
                    chk("i_waitrequest_done", 32'(i_waitrequest), 32'd0);
                    chk("i_readdata", i_readdata, e.rdata);
                    if (d_read || d_write) chk("d_waitrequest_blocked", 32'(d_waitrequest), 32'd1);
                end else begin
                    chk("d_waitrequest_done", 32'(d_waitrequest), 32'd0);
                    if (!e.wr) chk("d_readdata", d_readdata, e.rdata);
                    if (i_read) chk("i_waitrequest_blocked", 32'(i_waitrequest), 32'd1);
                end
            end
        end
    end

    initial begin
        // Reset state, with a fetch request held during reset.
        i_read = 1'b1;
        i_address = 32'h0000_0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_byteenable", 32'(byteenable), 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_i_waitrequest", 32'(i_waitrequest), 32'd1);
        chk("rst_d_waitrequest", 32'(d_waitrequest), 32'd0);
        step();
        i_read = 1'b0;
        reset = 1'b1;

        // Single fetch with zero wait states: one-cycle latency, then IDLE.
        step();
        i_read = 1'b1;
        i_address = 32'hBFC0_0000;
        readdata = 32'h2402_0005;
        waitrequest = 1'b0;
        push(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, 1'b1, 32'h2402_0005);
        @(negedge clk);
        chk("t1_not_yet_read", 32'(read), 32'd0);
        chk("t1_wait_before_grant", 32'(i_waitrequest), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_read_strobe", 32'(read), 32'd1);
        chk("t1_i_waitrequest", 32'(i_waitrequest), 32'd0);
        step();
        i_read = 1'b0;
        @(negedge clk);
        chk("t1_idle_after", 32'(read), 32'd0);

        // Unaligned store stalled three cycles by the bus.
        step();
        waitrequest = 1'b1;
        d_write = 1'b1;
        d_address = 32'h0000_1006;
        d_byteenable = 4'b0011;
        d_writedata = 32'hDEAD_BEEF;
        push(1'b0, 1'b1, 32'h0000_1004, 4'b0011, 32'hDEAD_BEEF, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t2_write_held", 32'(write), 32'd1);
            chk("t2_address_held", address, 32'h0000_1004);
            chk("t2_be_held", 32'(byteenable), 32'h3);
            chk("t2_wdata_held", writedata, 32'hDEAD_BEEF);
            chk("t2_d_wait_stall", 32'(d_waitrequest), 32'd1);
        end
        step();
        waitrequest = 1'b0;
        @(negedge clk);
        chk("t2_d_wait_done", 32'(d_waitrequest), 32'd0);
        step();
        d_write = 1'b0;

        // Simultaneous fetch and load: data first, then instruction.
        step();
        i_read = 1'b1;
        i_address = 32'h0000_0040;
        d_read = 1'b1;
        d_address = 32'h0000_0200;
        d_byteenable = 4'hF;
        readdata = 32'h1111_1111;
        push(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 1'b0, 32'h1111_1111);
        push(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b1, 32'h2222_2222);
        wait_done(1'b0, 20);
        step();
        d_read = 1'b0;
        readdata = 32'h2222_2222;
        wait_done(1'b1, 20);
        step();
        i_read = 1'b0;

        // Starvation guard: four data grants, then the waiting fetch, then data again.
        step();
        i_read = 1'b1;
        i_address = 32'h0000_0400;
        d_read = 1'b1;
        d_address = 32'h0000_2000;
        d_byteenable = 4'hF;
        readdata = 32'h3333_3333;
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0, 1'b0, 32'h3333_3333);
        push(1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'h0, 1'b1, 32'h3333_3333);
        push(1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0, 1'b0, 32'h3333_3333);
        wait_done(1'b1, 60);
        step();
        i_read = 1'b0;
        wait_done(1'b0, 20);
        step();
        d_read = 1'b0;

        // Asynchronous reset in the middle of a stalled data read.
        step();
        waitrequest = 1'b1;
        d_read = 1'b1;
        d_address = 32'h0000_3000;
        @(posedge clk);
        @(negedge clk);
        chk("t5_granted", 32'(read), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_read_drop", 32'(read), 32'd0);
        chk("t5_write_drop", 32'(write), 32'd0);
        chk("t5_no_done_pulse", 32'(d_waitrequest), 32'd1);
        d_read = 1'b0;
        step();
        waitrequest = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_idle_read", 32'(read), 32'd0);
        chk("t5_address_cleared", address, 32'd0);

        // Read and write together: write wins.
        step();
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 32'h0000_4008;
        d_byteenable = 4'hF;
        d_writedata = 32'h1234_5678;
        push(1'b0, 1'b1, 32'h0000_4008, 4'hF, 32'h1234_5678, 1'b0, 32'h0);
        wait_done(1'b0, 20);
        step();
        d_read = 1'b0;
        d_write = 1'b0;

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
Name: mips_cpu_bus_arbiter

Overview:
Shares one single-ported, Avalon-style memory bus between the CPU's instruction-fetch requester and data (load/store) requester. Latches the granted request and drives the shared bus until it completes. Stalls the losing requester through its waitrequest. Sits between the Harvard CPU core and a unified memory, so the core runs on a von Neumann bus without changing its fetch/exec sequencing.

Parameters:
MAX_CONSEC, 4, max consecutive data grants while an instruction request is pending before instruction is forced (starvation guard)
RESET_VECTOR_CHECK, 0, unused-by-logic tag; kept 0 (reserved)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 resets)
i_read  input  1  instruction fetch request
i_address  input  32  fetch byte address
i_readdata  output  32  fetch data, valid when i_read=1 and i_waitrequest=0
i_waitrequest  output  1  fetch stall
d_read  input  1  data read request
d_write  input  1  data write request
d_address  input  32  data byte address
d_byteenable  input  4  byte lanes for data access
d_writedata  input  32  store data
d_readdata  output  32  load data, valid when d_read=1 and d_waitrequest=0
d_waitrequest  output  1  data stall
address  output  32  shared bus address, bits[1:0] forced 00
read  output  1  shared bus read strobe
write  output  1  shared bus write strobe
byteenable  output  4  shared bus byte lanes
writedata  output  32  shared bus write data
readdata  input  32  shared bus read data, valid in cycle with read=1, waitrequest=0
waitrequest  input  1  shared bus stall

Behaviour:
- States (arb_state_t): IDLE, GRANT_I, GRANT_D.
- Reset (reset=0, async): state=IDLE, read=0, write=0, address=0, byteenable=0, writedata=0, consec_d=0, latched regs=0. i_waitrequest/d_waitrequest = 1 whenever corresponding request asserted and not completing (combinational), so 1 during reset if requested.
- IDLE arbitration (evaluated each cycle in IDLE):
  - data pending (d_read|d_write) and (no i_read or consec_d<MAX_CONSEC) -> GRANT_D, consec_d+1 if i_read else 0.
  - else i_read -> GRANT_I, consec_d=0.
  - else stay IDLE.
- On grant edge: latch address (bits[1:0]=00), byteenable (4'b1111 for instruction), writedata, and op. d_write and d_read both high -> write wins, read ignored.
- GRANT_x: read/write/address/byteenable/writedata driven from registers, held stable while waitrequest=1.
- Completion = GRANT_x and waitrequest=0: granted requester's waitrequest=0 that cycle; readdata passed combinationally to i_readdata/d_readdata. Next edge -> IDLE, strobes deassert.
- Always return to IDLE after completion (no back-to-back grant), so requester updates are never double-issued. Best-case latency: request in cycle N, completion in cycle N+1; peak throughput one transfer per 2 cycles.
- Writes: d_readdata undefined and ignored; d_waitrequest=0 on completion.
- Requester deasserting while granted is a protocol violation. The transaction still completes on the bus and the result is discarded.
- i_readdata/d_readdata equal readdata in all cycles; only the qualifier matters.
- Reset mid-transfer: strobes drop immediately (async); no completion reported.
- waitrequest held high forever: stays in GRANT_x indefinitely; no timeout.

Decomposition:
- Shared package mips_cpu_pkg: arb_state_t enum (2-bit, IDLE=00, GRANT_I=01, GRANT_D=10), bus op constants.
- No sub-module. Arbitration is a small combinational block inside this module.

Test Plan:
- i_read=1, i_address=0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1, address=0xBFC00000 one cycle after request; i_waitrequest=0 and i_readdata=0x24020005 that cycle; IDLE next.
- d_write=1, d_address=0x00001006, d_byteenable=0011, d_writedata=0xDEADBEEF, waitrequest high 3 cycles -> address=0x00001004, write held 3 cycles stable, d_waitrequest=1 until 4th bus cycle.
- i_read and d_read both asserted from same cycle -> GRANT_D first, then GRANT_I. i_waitrequest=1 throughout the data transfer.
- i_read held, d_read re-asserted continuously, MAX_CONSEC=4 -> four data grants, fifth grant GRANT_I, consec_d back to 0.
- reset=0 asserted mid-GRANT_D with waitrequest=1 -> read/write drop in the same cycle (async), state IDLE, no d_waitrequest=0 pulse.
- d_read=d_write=1, d_writedata=0x12345678 -> write=1, read=0 on bus.
